// File: rtl/ps_alter_arbiter.sv
// ps_alter_arbiter: arbitrates program-state change requests, drains the pipeline, then pulses o_alter.
// Define PS_ARB_RR_EN for round-robin arbitration; fixed priority (index 0 highest) otherwise.
package ps_alter_arbiter_pkg;
  typedef logic [31:0] program_state_t;
endpackage

module ps_alter_arbiter
  import ps_alter_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [NUM_REQ-1:0]  i_req_valid,
  input  program_state_t      i_req_ps [NUM_REQ],
  output logic [NUM_REQ-1:0]  o_req_ack,
  input  logic                i_pipe_idle,
  output logic                o_stall,
  output logic                o_alter,
  output program_state_t      o_ps,
  output logic [ID_W-1:0]     o_grant_id,
  output logic                o_busy
);
  typedef enum logic [1:0] {IDLE, QUIESCE, COMMIT} state_t;
  state_t state, state_nxt;
  program_state_t held;
  logic [ID_W-1:0] win;
  logic gnt;
  assign gnt = (state == IDLE) && |i_req_valid;
`ifdef PS_ARB_RR_EN
  logic [ID_W-1:0] ptr;
  logic found;
  int k;
  always_comb begin
    win = '0;
    found = 1'b0;
    k = 0;
    for (int j = 0; j < NUM_REQ; j++) begin
      k = (int'(ptr) + j) % NUM_REQ;
      if (!found && i_req_valid[k]) begin
        win = ID_W'(k);
        found = 1'b1;
      end
    end
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) ptr <= '0;
    else if (gnt) ptr <= (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
`else
  always_comb begin
    win = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--)
      if (i_req_valid[j]) win = ID_W'(j);
  end
`endif
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state <= IDLE;
      held <= '0;
      o_grant_id <= '0;
    end else begin
      state <= state_nxt;
      if (gnt) begin
        held <= i_req_ps[win];
        o_grant_id <= win;
      end
    end
  always_comb begin
    state_nxt = (state == IDLE)    ? (|i_req_valid ? QUIESCE : IDLE) :
                (state == QUIESCE) ? (i_pipe_idle ? COMMIT : QUIESCE) : IDLE;
    o_busy = state != IDLE;
    o_stall = state != IDLE;
    o_alter = state == COMMIT;
    o_req_ack = (state == COMMIT) ? NUM_REQ'(1) << o_grant_id : '0;
    o_ps = held;
  end
endmodule
